spi_mem_bridge: RTL

- Parametrised host-to-memory bridge between the SPI slave's byte stream and up to N_TGT on-chip memories (IRAM, DRAM, future peripherals RAM).
- A command/data protocol (dc_i) selects the target, sets a byte address, and streams auto-incrementing word writes or reads.
- Holds the CPU while the host owns any memory.
- Adds over the current loader: partial-word byte enables, read prefetch, target selection and explicit release.

---
 rtl/hxd_bridge_pkg.sv | 20 ++
 rtl/spi_word_pack.sv | 70 +++++++
 rtl/spi_mem_bridge.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/hxd_bridge_pkg.sv
// Shared types for the SPI-to-memory bridge: host command codes and bridge FSM states.
package hxd_bridge_pkg;

  typedef enum logic [7:0] {
    CMD_SET_ADDR = 8'h2A,
    CMD_WRITE    = 8'h2B,
    CMD_READ     = 8'h2C,
    CMD_SEL_TGT  = 8'h2D,
    CMD_RELEASE  = 8'h2E
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WR,
    RD,
    SELT
  } state_t;

endpackage

// File: rtl/spi_word_pack.sv
// Assembles host write bytes into a little-endian word with lane enables and
// emits a registered write strobe on a full word or on an explicit flush.
module spi_word_pack #(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int LW   = $clog2(NB)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            byte_vld_i,
  input  logic [LW-1:0]   lane_i,
  input  logic [7:0]      byte_i,
  input  logic            flush_i,
  output logic            pend_o,
  output logic            wr_en_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic [NB-1:0]   wr_be_o
);

  logic [XLEN-1:0] buf_q, buf_d;
  logic [NB-1:0]   be_q, be_d;
  logic            wr_en_q, wr_en_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [NB-1:0]   wr_be_q, wr_be_d;

  always_comb begin
    buf_d     = buf_q;
    be_d      = be_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    if (flush_i && (|be_q)) begin
      wr_en_d   = 1'b1;
      wr_data_d = buf_q;
      wr_be_d   = be_q;
      be_d      = '0;
    end else if (byte_vld_i) begin
      buf_d[{lane_i, 3'b000} +: 8] = byte_i;
      be_d[lane_i]                 = 1'b1;
      if (int'(lane_i) == NB - 1) begin
        wr_en_d   = 1'b1;
        wr_data_d = buf_d;
        wr_be_d   = be_d;
        be_d      = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q     <= '0;
      be_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
    end else begin
      buf_q     <= buf_d;
      be_q      <= be_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
    end
  end

  assign pend_o    = |be_q;
  assign wr_en_o   = wr_en_q;
  assign wr_data_o = wr_data_q;
  assign wr_be_o   = wr_be_q;

endmodule

// File: rtl/spi_mem_bridge.sv
// Host-to-memory bridge: decodes the SPI command/data byte stream into target
// selection, auto-incrementing word writes and prefetched reads.
//
// state | meaning
// IDLE  | no command active, data bytes ignored
// ADDR  | data bytes load the byte address, little-endian
// WR    | data bytes fill write lanes, full words are committed
// RD    | data bytes advance the read lane, word refetched on wrap
// SELT  | first data byte selects the target memory
module spi_mem_bridge import hxd_bridge_pkg::*; #(
  parameter  int XLEN     = 32,
  parameter  int ADDR_W   = 32,
  parameter  int N_TGT    = 2,
  parameter  int BOOT_OWN = 1,
  localparam int NB       = XLEN / 8,
  localparam int LW       = $clog2(NB),
  localparam int TW       = $clog2(N_TGT)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              dc_i,
  input  logic              spi_byte_vld_i,
  input  logic [7:0]        spi_byte_data_i,
  output logic [7:0]        spi_byte_data_o,
  output logic [N_TGT-1:0]  host_own_o,
  output logic              cpu_hold_o,
  output logic [TW-1:0]     tgt_sel_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [XLEN-1:0]   wr_data_o,
  output logic [NB-1:0]     wr_byte_en_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [XLEN-1:0]   rd_data_i
);

  localparam int AB = ADDR_W / 8;
  localparam int IW = $clog2(AB + 1);
  localparam logic [N_TGT-1:0] OWN_RST =
    (BOOT_OWN != 0) ? {{(N_TGT-1){1'b0}}, 1'b1} : '0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              sel_done_q, sel_done_d;
  logic [N_TGT-1:0]  host_own_q, host_own_d;
  logic [TW-1:0]     tgt_sel_q, tgt_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              rd_lat_q, rd_lat_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_word_q, rd_word_d;
  logic [7:0]        miso_q, miso_d;

  logic cmd_vld, dat_vld, own, lane_last, pk_vld, pk_flush, pk_pend;

  assign cmd_vld   = spi_byte_vld_i && !dc_i;
  assign dat_vld   = spi_byte_vld_i && dc_i;
  assign own       = host_own_q[tgt_sel_q];
  assign lane_last = (int'(lane_q) == NB - 1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lane_d     = lane_q;
    idx_d      = idx_q;
    sel_done_d = sel_done_q;
    host_own_d = host_own_q;
    tgt_sel_d  = tgt_sel_q;
    wr_addr_d  = wr_addr_q;
    rd_en_d    = 1'b0;
    rd_lat_d   = rd_en_q;
    rd_addr_d  = rd_addr_q;
    rd_word_d  = rd_lat_q ? rd_data_i : rd_word_q;
    pk_vld     = 1'b0;
    pk_flush   = 1'b0;

    if (cmd_vld) begin
      // a partially filled word is committed at the current word address
      pk_flush = 1'b1;
      if (pk_pend) wr_addr_d = {addr_q[ADDR_W-1:LW], {LW{1'b0}}};
      case (spi_byte_data_i)
        CMD_SET_ADDR: begin
          state_d = ADDR;
          idx_d   = '0;
        end
        CMD_WRITE: begin
          state_d = WR;
          lane_d  = addr_q[LW-1:0];
        end
        CMD_READ: begin
          state_d   = RD;
          lane_d    = addr_q[LW-1:0];
          rd_en_d   = own;
          rd_addr_d = {addr_q[ADDR_W-1:LW], {LW{1'b0}}};
        end
        CMD_SEL_TGT: begin
          state_d    = SELT;
          sel_done_d = 1'b0;
        end
        CMD_RELEASE: begin
          state_d    = IDLE;
          host_own_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end else if (dat_vld) begin
      case (state_q)
        ADDR: begin
          if (int'(idx_q) < AB) begin
            addr_d[{idx_q, 3'b000} +: 8] = spi_byte_data_i;
            idx_d = idx_q + 1'b1;
          end
        end
        SELT: begin
          if (!sel_done_q) begin
            sel_done_d = 1'b1;
            if (32'(spi_byte_data_i) < N_TGT) begin
              tgt_sel_d = spi_byte_data_i[TW-1:0];
              for (int t = 0; t < N_TGT; t++) host_own_d[t] = (spi_byte_data_i == 8'(t));
            end
          end
        end
        WR: begin
          pk_vld = own;
          if (lane_last) begin
            if (own) wr_addr_d = {addr_q[ADDR_W-1:LW], {LW{1'b0}}};
            addr_d = addr_q + ADDR_W'(NB);
            lane_d = '0;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
        RD: begin
          if (lane_last) begin
            addr_d    = addr_q + ADDR_W'(NB);
            lane_d    = '0;
            rd_en_d   = own;
            rd_addr_d = {addr_d[ADDR_W-1:LW], {LW{1'b0}}};
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    miso_d = ((state_d == RD) && own) ? rd_word_d[{lane_d, 3'b000} +: 8] : 8'hFF;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      lane_q     <= '0;
      idx_q      <= '0;
      sel_done_q <= 1'b0;
      host_own_q <= OWN_RST;
      tgt_sel_q  <= '0;
      wr_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_lat_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_word_q  <= '0;
      miso_q     <= 8'hFF;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      lane_q     <= lane_d;
      idx_q      <= idx_d;
      sel_done_q <= sel_done_d;
      host_own_q <= host_own_d;
      tgt_sel_q  <= tgt_sel_d;
      wr_addr_q  <= wr_addr_d;
      rd_en_q    <= rd_en_d;
      rd_lat_q   <= rd_lat_d;
      rd_addr_q  <= rd_addr_d;
      rd_word_q  <= rd_word_d;
      miso_q     <= miso_d;
    end
  end

  spi_word_pack #(.XLEN(XLEN)) u_pack (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .byte_vld_i (pk_vld),
    .lane_i     (lane_q),
    .byte_i     (spi_byte_data_i),
    .flush_i    (pk_flush),
    .pend_o     (pk_pend),
    .wr_en_o    (wr_en_o),
    .wr_data_o  (wr_data_o),
    .wr_be_o    (wr_byte_en_o)
  );

  assign spi_byte_data_o = miso_q;
  assign host_own_o      = host_own_q;
  assign cpu_hold_o      = |host_own_q;
  assign tgt_sel_o       = tgt_sel_q;
  assign wr_addr_o       = wr_addr_q;
  assign rd_en_o         = rd_en_q;
  assign rd_addr_o       = rd_addr_q;

endmodule
